// File: rtl/avg_dc_remove_if.sv
// ---------------------------------------------------------------------------
// avg_dc_remove_if -- sample-stream bundle for the avg_dc_remove block.
//
// Signals (names are from the block's point of view):
//   en_i      block enable
//   valid_i   data_i carries a sample this cycle
//   data_i    signed input sample, WIDTH bits
//   clear_i   synchronous flush of the averaging window
//   valid_o   one-cycle strobe: data_o / mean_o were just updated
//   data_o    signed result (DC-removed sample or mean, per MODE)
//   mean_o    signed running mean of the window
//   primed_o  window holds a full set of real samples
//
// Modports: master drives the inputs (source side), slave is the block.
// ---------------------------------------------------------------------------
interface avg_dc_remove_if #(
  parameter int WIDTH = 16
);
  logic                    en_i;
  logic                    valid_i;
  logic signed [WIDTH-1:0] data_i;
  logic                    clear_i;
  logic                    valid_o;
  logic signed [WIDTH-1:0] data_o;
  logic signed [WIDTH-1:0] mean_o;
  logic                    primed_o;

  modport master (
    output en_i, valid_i, data_i, clear_i,
    input  valid_o, data_o, mean_o, primed_o
  );

  modport slave (
    input  en_i, valid_i, data_i, clear_i,
    output valid_o, data_o, mean_o, primed_o
  );
endinterface

// File: rtl/avg_dc_remove.sv
// ---------------------------------------------------------------------------
// avg_dc_remove -- moving-average DC estimator / remover.
//
// Keeps the last DEPTH = 2^LOG2_DEPTH accepted samples in a circular buffer
// together with their running sum. Each accepted sample produces, one edge
// later, the window mean (floor of sum / DEPTH, current sample included) and
// either sample - mean (MODE 0) or the mean itself (MODE 1).
//
// Ports:
//   clk   clock, rising-edge
//   rst   asynchronous active-low reset (clears window and outputs)
//   bus   avg_dc_remove_if.slave: en_i, valid_i, data_i, clear_i in;
//         valid_o, data_o, mean_o, primed_o out (all registered)
//
// Build option:
//   AVG_DC_SAT_EN  when defined, the MODE-0 difference saturates to the
//                  WIDTH-bit signed range; otherwise it wraps.
// ---------------------------------------------------------------------------
module avg_dc_remove #(
  parameter int WIDTH      = 16,
  parameter int LOG2_DEPTH = 7,
  parameter int MODE       = 0
) (
  input  logic           clk,
  input  logic           rst,
  avg_dc_remove_if.slave bus
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = WIDTH + LOG2_DEPTH;
  localparam int CNT_W = LOG2_DEPTH + 1;

  localparam logic [LOG2_DEPTH-1:0] PTR_ONE    = LOG2_DEPTH'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_DEPTH  = CNT_W'(DEPTH);

`ifdef AVG_DC_SAT_EN
  // Clamp a WIDTH+1-bit signed difference into the WIDTH-bit signed range.
  function automatic logic signed [WIDTH-1:0] sat_reduce(input logic signed [WIDTH:0] d);
    logic signed [WIDTH-1:0] r;
    if (d[WIDTH] != d[WIDTH-1]) begin
      r = d[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      r = d[WIDTH-1:0];
    end
    return r;
  endfunction
`endif

  // Window state
  logic signed [WIDTH-1:0] mem_q [DEPTH];
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic [LOG2_DEPTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]        fill_q, fill_d;

  // Output registers
  logic signed [WIDTH-1:0] data_q, data_d;
  logic signed [WIDTH-1:0] mean_q, mean_d;
  logic                    valid_q, valid_d;
  logic                    primed_q, primed_d;

  // Datapath intermediates
  logic                    clear_s;
  logic                    accept_s;
  logic signed [SUM_W-1:0] sum_upd_s;
  logic signed [WIDTH-1:0] mean_s;
  logic signed [WIDTH-1:0] diff_s;
`ifdef AVG_DC_SAT_EN
  logic signed [WIDTH:0]   diff_wide_s;
`endif

  // en_i low freezes everything, including a pending flush.
  assign clear_s  = bus.en_i & bus.clear_i;
  assign accept_s = bus.en_i & bus.valid_i & ~bus.clear_i;

  // Sum update, mean and sample-minus-mean for the sample being accepted.
  always_comb begin
    sum_upd_s = sum_q
              + {{LOG2_DEPTH{bus.data_i[WIDTH-1]}}, bus.data_i}
              - {{LOG2_DEPTH{mem_q[wr_ptr_q][WIDTH-1]}}, mem_q[wr_ptr_q]};
    // Upper bits of the sum are the arithmetic right shift by LOG2_DEPTH
    // (floor division); the mean always fits in WIDTH bits.
    mean_s = sum_upd_s[SUM_W-1:LOG2_DEPTH];
`ifdef AVG_DC_SAT_EN
    diff_wide_s = {bus.data_i[WIDTH-1], bus.data_i} - {mean_s[WIDTH-1], mean_s};
    diff_s      = sat_reduce(diff_wide_s);
`else
    // Low WIDTH bits of the WIDTH+1-bit difference are a WIDTH-bit subtract.
    diff_s = bus.data_i - mean_s;
`endif
  end

  // Next-state selection: flush beats acceptance; otherwise hold.
  always_comb begin
    sum_d    = sum_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    data_d   = data_q;
    mean_d   = mean_q;
    valid_d  = 1'b0;
    if (clear_s) begin
      sum_d    = '0;
      wr_ptr_d = '0;
      fill_d   = '0;
    end else if (accept_s) begin
      sum_d    = sum_upd_s;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      fill_d   = (fill_q == CNT_DEPTH) ? fill_q : (fill_q + CNT_ONE);
      mean_d   = mean_s;
      data_d   = (MODE == 1) ? mean_s : diff_s;
      valid_d  = 1'b1;
    end else begin
      valid_d  = 1'b0;
    end
    primed_d = (fill_d == CNT_DEPTH);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q    <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      data_q   <= '0;
      mean_q   <= '0;
      valid_q  <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      sum_q    <= sum_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      data_q   <= data_d;
      mean_q   <= mean_d;
      valid_q  <= valid_d;
      primed_q <= primed_d;
    end
  end

  // Sample buffer; zeroed entries stand in for samples not yet received.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (accept_s) begin
      mem_q[wr_ptr_q] <= bus.data_i;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign bus.valid_o  = valid_q;
  assign bus.data_o   = data_q;
  assign bus.mean_o   = mean_q;
  assign bus.primed_o = primed_q;

endmodule

// File: tb/tb_avg_dc_remove.sv
// ---------------------------------------------------------------------------
// tb_avg_dc_remove -- directed, table-driven bench for avg_dc_remove with
// WIDTH=16, LOG2_DEPTH=2. Two instances share identical stimulus: u_m0
// (MODE 0) and u_m1 (MODE 1, data_o carries the mean).
// ---------------------------------------------------------------------------
module tb_avg_dc_remove;

  localparam int W  = 16;
  localparam int LD = 2;

  logic clk;
  logic rst;

  avg_dc_remove_if #(.WIDTH(W)) if_m0 ();
  avg_dc_remove_if #(.WIDTH(W)) if_m1 ();

  avg_dc_remove #(.WIDTH(W), .LOG2_DEPTH(LD), .MODE(0)) u_m0 (
    .clk (clk),
    .rst (rst),
    .bus (if_m0.slave)
  );

  avg_dc_remove #(.WIDTH(W), .LOG2_DEPTH(LD), .MODE(1)) u_m1 (
    .clk (clk),
    .rst (rst),
    .bus (if_m1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic               en;
    logic               valid;
    logic               clear;
    logic signed [15:0] data;
    logic               exp_valid;
    logic signed [15:0] exp_data;
    logic signed [15:0] exp_mean;
    logic               exp_primed;
  } vec_t;

  vec_t vecs [17];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic valid, input logic clear,
                       input logic signed [15:0] data);
    if_m0.en_i = en;   if_m0.valid_i = valid; if_m0.clear_i = clear; if_m0.data_i = data;
    if_m1.en_i = en;   if_m1.valid_i = valid; if_m1.clear_i = clear; if_m1.data_i = data;
  endtask

  // Drive on the falling edge, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic en, input logic valid, input logic clear,
                      input logic signed [15:0] data);
    @(negedge clk);
    drive(en, valid, clear, data);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 16'sd0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"},   int'(if_m0.valid_o),  0);
    chk({tag, "_data"},    int'(if_m0.data_o),   0);
    chk({tag, "_mean"},    int'(if_m0.mean_o),   0);
    chk({tag, "_primed"},  int'(if_m0.primed_o), 0);
    chk({tag, "_m1_data"}, int'(if_m1.data_o),   0);
  endtask

  initial begin
    logic signed [15:0] exp_sat;

    // Startup from reset -> 4x100 fill -> 8x100 wrap -> clear vs valid
    // -> sample 8 -> en_i low -> sample 8 (proves nothing was taken) -> idle.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 16'sd100, 1'b1, 16'sd75,  16'sd25,  1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 16'sd100, 1'b1, 16'sd50,  16'sd50,  1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 16'sd100, 1'b1, 16'sd25,  16'sd75,  1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 16'sd100, 1'b1, 16'sd0,   16'sd100, 1'b1};
    for (int i = 4; i < 12; i++) begin
      vecs[i] = '{1'b1, 1'b1, 1'b0, 16'sd100, 1'b1, 16'sd0, 16'sd100, 1'b1};
    end
    vecs[12] = '{1'b1, 1'b1, 1'b1, 16'sd50,  1'b0, 16'sd0,   16'sd100, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 16'sd8,   1'b1, 16'sd6,   16'sd2,   1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 16'sd99,  1'b0, 16'sd6,   16'sd2,   1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 16'sd8,   1'b1, 16'sd4,   16'sd4,   1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 16'sd77,  1'b0, 16'sd4,   16'sd4,   1'b0};

    // Power-up reset: outputs must be zero while rst is low.
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'sd0);
    #1 rst = 1'b0;
    #2;
    chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].en, vecs[i].valid, vecs[i].clear, vecs[i].data);
      chk($sformatf("v%0d_valid", i),   int'(if_m0.valid_o),  int'(vecs[i].exp_valid));
      chk($sformatf("v%0d_data", i),    int'(if_m0.data_o),   int'(vecs[i].exp_data));
      chk($sformatf("v%0d_mean", i),    int'(if_m0.mean_o),   int'(vecs[i].exp_mean));
      chk($sformatf("v%0d_primed", i),  int'(if_m0.primed_o), int'(vecs[i].exp_primed));
      chk($sformatf("v%0d_m1_data", i), int'(if_m1.data_o),   int'(vecs[i].exp_mean));
    end

    // Single negative sample: floor rounding of the mean.
    do_reset();
    step(1'b1, 1'b1, 1'b0, -16'sd5);
    chk("neg_valid",   int'(if_m0.valid_o), 1);
    chk("neg_mean",    int'(if_m0.mean_o),  -2);
    chk("neg_data",    int'(if_m0.data_o),  -3);
    chk("neg_m1_data", int'(if_m1.data_o),  -2);

    // Full-scale negative window, then full-scale positive sample.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, -16'sd32768);
    end
    chk("min_primed", int'(if_m0.primed_o), 1);
    chk("min_mean",   int'(if_m0.mean_o),   -32768);
    step(1'b1, 1'b1, 1'b0, 16'sd32767);
`ifdef AVG_DC_SAT_EN
    exp_sat = 16'sd32767;
`else
    exp_sat = -16'sd16384;
`endif
    chk("edge_mean",    int'(if_m0.mean_o), -16385);
    chk("edge_data",    int'(if_m0.data_o), int'(exp_sat));
    chk("edge_m1_data", int'(if_m1.data_o), -16385);

    // Asynchronous reset pulse between edges while primed.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'sd10);
    end
    chk("pre_primed", int'(if_m0.primed_o), 1);
    chk("pre_valid",  int'(if_m0.valid_o),  1);
    chk("pre_mean",   int'(if_m0.mean_o),   10);
    drive(1'b1, 1'b0, 1'b0, 16'sd0);
    #1 rst = 1'b0;
    #1;
    chk_zero("async");
    #1 rst = 1'b1;
    step(1'b1, 1'b1, 1'b0, 16'sd40);
    chk("post_valid",   int'(if_m0.valid_o),  1);
    chk("post_data",    int'(if_m0.data_o),   30);
    chk("post_mean",    int'(if_m0.mean_o),   10);
    chk("post_primed",  int'(if_m0.primed_o), 0);
    chk("post_m1_data", int'(if_m1.data_o),   10);
    step(1'b1, 1'b0, 1'b0, 16'sd0);
    chk("post_strobe",  int'(if_m0.valid_o),  0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/avg_dc_remove.md
AVG_DC_REMOVE -- requirements
Module: avg_dc_remove

Interface
REQ-001 Parameter WIDTH, default 16, is the signed sample width of data_i, data_o and mean_o.
REQ-002 Parameter LOG2_DEPTH, default 7, sets the window DEPTH = 2^LOG2_DEPTH samples; legal range 1..10.
REQ-003 Parameter MODE, default 0, selects the data_o source: 0 = sample minus mean (DC removal), 1 = mean only.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 en_i  input  1  block enable; samples are accepted only while high.
REQ-007 valid_i  input  1  data_i is valid this cycle.
REQ-008 data_i  input  WIDTH  signed input sample.
REQ-009 clear_i  input  1  synchronous flush of the window.
REQ-010 valid_o  output  1  one-cycle strobe: data_o and mean_o are updated.
REQ-011 data_o  output  WIDTH  signed result selected by MODE.
REQ-012 mean_o  output  WIDTH  signed running mean of the window.
REQ-013 primed_o  output  1  window holds DEPTH real samples.

Function
REQ-014 Accept a sample on any rising edge where en_i=1, valid_i=1 and clear_i=0; ignore valid_i in every other case.
REQ-015 Store samples in a DEPTH-entry circular buffer indexed by a LOG2_DEPTH-bit write pointer that wraps from DEPTH-1 to 0.
REQ-016 On acceptance, update sum <= sum + data_i - buff[wr_ptr], then buff[wr_ptr] <= data_i and wr_ptr <= wr_ptr+1, all on the same edge.
REQ-017 Hold sum as a signed WIDTH+LOG2_DEPTH-bit register; it never overflows.
REQ-018 Compute mean = updated sum >>> LOG2_DEPTH (arithmetic shift, rounds toward minus infinity), so the current sample is included.
REQ-019 Compute the difference as sample - mean at WIDTH+1 bits, then reduce it to WIDTH bits per REQ-031/REQ-032.
REQ-020 Register data_o, mean_o and valid_o on the acceptance edge: latency is one edge, and valid_o is high for exactly the following cycle.
REQ-021 Hold data_o and mean_o between strobes; valid_o=0 whenever no sample was accepted on the previous edge.
REQ-022 Fill counter counts accepted samples and saturates at DEPTH; primed_o=1 while fill counter = DEPTH.
REQ-023 Before priming, empty buffer entries read as zero; the mean is not renormalised.
REQ-024 clear_i=1 zeroes sum, wr_ptr, fill counter and all buffer entries on the next edge.
REQ-025 clear_i=1 drives valid_o=0 on the next edge; data_o and mean_o hold.
REQ-026 clear_i has priority over a simultaneous valid_i; that sample is discarded.
REQ-027 en_i=0 freezes all state; valid_o=0.

Reset
REQ-028 rst=0 immediately, without waiting for a clock edge, clears sum, wr_ptr, fill counter, all buffer entries, data_o, mean_o, valid_o and primed_o to 0.
REQ-029 rst=0 in the middle of operation discards the window; the first accepted sample after release behaves as the first sample after power-up.
REQ-030 Release of rst is synchronised by the integrator; the block requires no sample on the release edge.

Configuration
REQ-031 With macro AVG_DC_SAT_EN defined, clamp the MODE-0 difference to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-032 Without AVG_DC_SAT_EN, keep the low WIDTH bits of the difference (two's-complement wrap); mean_o is unaffected in both builds.

Verification (WIDTH=16, LOG2_DEPTH=2, MODE=0 unless stated)
REQ-033 After reset, four samples of 100 -> data_o 75, 50, 25, 0; mean_o 25, 50, 75, 100; primed_o=1 after the fourth.
REQ-034 Eight further samples of 100 (pointer wraps twice) -> data_o=0 and mean_o=100 each time; sum stays 400.
REQ-035 After reset, single sample -5 -> mean_o=-2 (floor), data_o=-3.
REQ-036 Four samples of -32768, then 32767 -> mean_o=-16385; data_o=32767 with AVG_DC_SAT_EN, -16384 without.
REQ-037 clear_i and valid_i with data 50 on the same edge -> valid_o=0 and primed_o=0; then sample 8 -> data_o=6, mean_o=2; en_i=0 with valid_i=1 -> no valid_o and no state change.
REQ-038 rst pulsed low between edges while primed -> all outputs 0 before the next edge; then sample 40 -> data_o=30; repeat with MODE=1 -> data_o=10.
